// File: rtl/fwrisc_mem_arb_if.sv
// Signal bundle between the fetch/data requesters, the memory arbiter and the memory bus.
// The master modport is the arbiter's view; slave is the view of the surrounding logic.
interface fwrisc_mem_arb_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic        d_write;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic [31:0] maddr;
  logic [31:0] mdata;
  logic [3:0]  mstrb;
  logic        mwrite;
  logic        mvalid;
  logic        mready;
  logic [31:0] mrdata;

  logic        err;

  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_strb, d_write, mready, mrdata,
    output i_ready, i_rdata, d_ready, d_rdata, maddr, mdata, mstrb, mwrite, mvalid, err
  );

  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_strb, d_write, mready, mrdata,
    input  i_ready, i_rdata, d_ready, d_rdata, maddr, mdata, mstrb, mwrite, mvalid, err
  );
endinterface

// File: rtl/fwrisc_mem_arb.sv
// Arbitrates the single fwrisc memory port between fetch (I) and load/store (D), one transaction
// at a time, with a response watchdog. Define FWRISC_MEM_ARB_RR_EN for round-robin arbitration.
module fwrisc_mem_arb #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  fwrisc_mem_arb_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReqI, StReqD, StRspI, StRspD} state_e;

  localparam bit          WdEn        = (MAX_WAIT != 0);
  localparam int unsigned WaitLastInt = WdEn ? MAX_WAIT - 1 : 0;
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WaitLastInt);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        mstrb_q, mstrb_d;
  logic              mwrite_q, mwrite_d;
  logic              err_q, err_d;
  logic              in_req, i_rsp, d_rsp, wd_expire, grant_d;

  assign in_req    = (state_q == StReqI) || (state_q == StReqD);
  assign i_rsp     = (state_q == StRspI);
  assign d_rsp     = (state_q == StRspD);
  assign wd_expire = WdEn && (cnt_q == WaitLast);

`ifdef FWRISC_MEM_ARB_RR_EN
  // last_d_q: 1 when the most recent grant went to D
  logic last_d_q, last_d_d;
  assign grant_d = bus.d_valid && (!bus.i_valid || !last_d_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign grant_d = bus.d_valid;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mstrb_d  = mstrb_q;
    mwrite_d = mwrite_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
`ifdef FWRISC_MEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d  = StReqD;
          cnt_d    = '0;
          maddr_d  = bus.d_addr;
          mdata_d  = bus.d_wdata;
          mstrb_d  = bus.d_strb;
          mwrite_d = bus.d_write;
`ifdef FWRISC_MEM_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (bus.i_valid) begin
          state_d  = StReqI;
          cnt_d    = '0;
          maddr_d  = bus.i_addr;
          mdata_d  = '0;
          mstrb_d  = 4'hf;
          mwrite_d = 1'b0;
`ifdef FWRISC_MEM_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      StReqI, StReqD: begin
        // A handshake in the expiry cycle takes precedence over the watchdog
        if (bus.mready) begin
          rdata_d = bus.mrdata;
          state_d = (state_q == StReqD) ? StRspD : StRspI;
        end else if (wd_expire) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = (state_q == StReqD) ? StRspD : StRspI;
        end else if (WdEn) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRspI, StRspD: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mstrb_q  <= '0;
      mwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      mstrb_q  <= mstrb_d;
      mwrite_q <= mwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.mvalid  = in_req;
  assign bus.maddr   = maddr_q;
  assign bus.mdata   = mdata_q;
  assign bus.mstrb   = mstrb_q;
  assign bus.mwrite  = mwrite_q;
  assign bus.i_ready = i_rsp;
  assign bus.d_ready = d_rsp;
  assign bus.i_rdata = i_rsp ? rdata_q : '0;
  assign bus.d_rdata = d_rsp ? rdata_q : '0;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Self-checking bench for fwrisc_mem_arb: transaction-level model plus directed vectors.
module tb_fwrisc_mem_arb;

  localparam int unsigned MaxWait = 16;
  localparam logic [31:0] RdXor   = 32'h1234_5678;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fwrisc_mem_arb_if bus ();

  fwrisc_mem_arb #(
    .MAX_WAIT(MaxWait),
    .CNT_W   (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory responder knobs
  int resp_wait;
  bit idle_noise;

  // Model state: expected outputs for the current cycle
  bit          m_live;
  bit          e_mvalid, e_iready, e_dready, e_err, e_who_d, e_mwrite;
  logic [31:0] e_maddr, e_mdata, e_rdata;
  logic [3:0]  e_mstrb;
  int          m_waited;
  bit          m_last_d;
  bit          rr_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int nmv);
    nmv = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.mvalid === 1'b1) nmv++;
      if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ready: no ready pulse within 200 cycles, expected one");
  endtask

  // Memory: accept after resp_wait stalled cycles; data is the address scrambled
  initial begin
    int age;
    age = 0;
    bus.mready = 1'b0;
    bus.mrdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.mvalid === 1'b1) begin
        bus.mready = (age == resp_wait);
        age = bus.mready ? 0 : age + 1;
      end else begin
        bus.mready = idle_noise;
        age = 0;
      end
      bus.mrdata = bus.maddr ^ RdXor;
    end
  end

  // Transaction model: a request is granted from an idle cycle, waits for mready or
  // MaxWait stalled cycles, answers for one cycle, then one idle cycle follows.
  initial begin
    m_live = 1'b0;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_live = 1'b1;
        e_mvalid = 1'b0; e_iready = 1'b0; e_dready = 1'b0; e_err = 1'b0;
        e_rdata = '0; m_waited = 0; m_last_d = 1'b0;
      end else if (m_live) begin
        if (e_iready || e_dready) begin
          e_iready = 1'b0; e_dready = 1'b0; e_err = 1'b0;
        end else if (e_mvalid) begin
          m_waited++;
          if (bus.mready) begin
            e_mvalid = 1'b0; e_rdata = bus.mrdata; e_err = 1'b0;
            e_dready = e_who_d; e_iready = !e_who_d;
          end else if (MaxWait != 0 && m_waited == MaxWait) begin
            e_mvalid = 1'b0; e_rdata = '0; e_err = 1'b1;
            e_dready = e_who_d; e_iready = !e_who_d;
          end
        end else if (bus.i_valid || bus.d_valid) begin
          e_who_d  = bus.d_valid && (!bus.i_valid || !rr_mode || !m_last_d);
          m_last_d = e_who_d;
          e_mvalid = 1'b1;
          m_waited = 0;
          e_maddr  = e_who_d ? bus.d_addr : bus.i_addr;
          e_mdata  = bus.d_wdata;
          e_mstrb  = e_who_d ? bus.d_strb : 4'hf;
          e_mwrite = e_who_d ? bus.d_write : 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      if (m_live) begin
        chk("mvalid", {31'd0, bus.mvalid}, {31'd0, e_mvalid});
        chk("i_ready", {31'd0, bus.i_ready}, {31'd0, e_iready});
        chk("d_ready", {31'd0, bus.d_ready}, {31'd0, e_dready});
        chk("err", {31'd0, bus.err}, {31'd0, e_err});
        if (e_mvalid) begin
          chk("maddr", bus.maddr, e_maddr);
          chk("mstrb", {28'd0, bus.mstrb}, {28'd0, e_mstrb});
          chk("mwrite", {31'd0, bus.mwrite}, {31'd0, e_mwrite});
          if (e_who_d) chk("mdata", bus.mdata, e_mdata);
        end
        if (e_iready) chk("i_rdata", bus.i_rdata, e_rdata);
        if (e_dready) chk("d_rdata", bus.d_rdata, e_rdata);
      end
    end
  end

  initial begin
    int n;
    bit got_d [4];
    bit exp_d [4];
    checks = 0;
    errors = 0;
`ifdef FWRISC_MEM_ARB_RR_EN
    rr_mode = 1'b1;
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    rr_mode = 1'b0;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    resp_wait = 0;
    idle_noise = 1'b0;
    reset = 1'b1;
    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_strb = '0; bus.d_write = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_mvalid", {31'd0, bus.mvalid}, 32'd0);
    chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_maddr", bus.maddr, 32'd0);
    chk("rst_mdata", bus.mdata, 32'd0);
    chk("rst_mstrb", {28'd0, bus.mstrb}, 32'd0);
    chk("rst_mwrite", {31'd0, bus.mwrite}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    reset = 1'b0;

    // Fetch with mready tied high: mvalid in cycle 2, i_ready in cycle 3
    bus.i_valid = 1'b1; bus.i_addr = 32'h100;
    tick();
    chk("t1_mvalid", {31'd0, bus.mvalid}, 32'd1);
    chk("t1_maddr", bus.maddr, 32'h100);
    chk("t1_mstrb", {28'd0, bus.mstrb}, 32'hf);
    chk("t1_mwrite", {31'd0, bus.mwrite}, 32'd0);
    tick();
    chk("t1_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("t1_i_rdata", bus.i_rdata, 32'h1234_5778);
    bus.i_valid = 1'b0;
    tick();
    chk("t1_i_ready_pulse", {31'd0, bus.i_ready}, 32'd0);

    // Store with 4 stall cycles: payload stable for 5 cycles
    resp_wait = 4;
    bus.d_valid = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hdead_beef;
    bus.d_strb = 4'b0011; bus.d_write = 1'b1;
    tick();
    n = 0;
    while (bus.mvalid === 1'b1 && n < 50) begin
      chk("t2_maddr", bus.maddr, 32'h2000);
      chk("t2_mdata", bus.mdata, 32'hdead_beef);
      chk("t2_mstrb", {28'd0, bus.mstrb}, 32'h3);
      chk("t2_mwrite", {31'd0, bus.mwrite}, 32'd1);
      n++;
      tick();
    end
    chk("t2_mvalid_cycles", n, 32'd5);
    chk("t2_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("t2_err", {31'd0, bus.err}, 32'd0);
    bus.d_valid = 1'b0;
    tick();
    chk("t2_d_ready_pulse", {31'd0, bus.d_ready}, 32'd0);

    // Requester drops valid mid-flight; completion still pulses
    resp_wait = 2;
    bus.i_valid = 1'b1; bus.i_addr = 32'h700;
    tick();
    bus.i_valid = 1'b0;
    wait_ready(n);
    chk("t2b_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("t2b_i_rdata", bus.i_rdata, 32'h1234_5178);

    // Simultaneous requests held high, four grants
    resp_wait = 0;
    bus.i_valid = 1'b1; bus.i_addr = 32'h400;
    bus.d_valid = 1'b1; bus.d_addr = 32'h3000; bus.d_write = 1'b0; bus.d_strb = 4'hf;
    for (int j = 0; j < 4; j++) begin
      wait_ready(n);
      got_d[j] = bus.d_ready;
      chk($sformatf("t3_grant%0d_is_d", j), {31'd0, got_d[j]}, {31'd0, exp_d[j]});
    end
    bus.i_valid = 1'b0; bus.d_valid = 1'b0;
    repeat (2) tick();

    // Memory never answers: watchdog completion after MaxWait cycles; idle mready ignored
    resp_wait = 1000;
    idle_noise = 1'b1;
    bus.d_valid = 1'b1; bus.d_addr = 32'h44;
    wait_ready(n);
    chk("t4_mvalid_cycles", n, 32'd16);
    chk("t4_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_d_rdata", bus.d_rdata, 32'd0);
    bus.d_valid = 1'b0;
    tick();
    chk("t4_idle_mvalid", {31'd0, bus.mvalid}, 32'd0);
    chk("t4_err_pulse", {31'd0, bus.err}, 32'd0);
    repeat (3) tick();
    idle_noise = 1'b0;

    // Reset while a fetch is outstanding, then a fresh fetch
    bus.i_valid = 1'b1; bus.i_addr = 32'h500;
    tick();
    chk("t5_mvalid", {31'd0, bus.mvalid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_mvalid_after_rst", {31'd0, bus.mvalid}, 32'd0);
    chk("t5_i_ready_after_rst", {31'd0, bus.i_ready}, 32'd0);
    reset = 1'b0;
    resp_wait = 0;
    bus.i_addr = 32'h600;
    wait_ready(n);
    chk("t5_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("t5_i_rdata", bus.i_rdata, 32'h1234_5078);
    bus.i_valid = 1'b0;
    repeat (2) tick();

    // Handshake in the very last watchdog cycle completes normally
    resp_wait = 15;
    bus.d_valid = 1'b1; bus.d_addr = 32'h80;
    wait_ready(n);
    chk("t6_mvalid_cycles", n, 32'd16);
    chk("t6_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("t6_err", {31'd0, bus.err}, 32'd0);
    chk("t6_d_rdata", bus.d_rdata, 32'h1234_56f8);
    bus.d_valid = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
